three_input_gate_sequencer: RTL and testbench

THREE_INPUT_GATE_SEQUENCER -- requirements
Module: three_input_gate_sequencer

---
 rtl/three_input_gate_sequencer.sv | 110 +++++++++++
 tb/tb_three_input_gate_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/three_input_gate_sequencer.sv
// Exhaustive 3-input NOR gate tester: steps {A,B,C} through 000..111, samples D and counts mismatches.
// Optional macro NOR_SEQ_CAPTURE_EN adds an 8-bit RESP register holding D for each vector.
module three_input_gate_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       D,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] VEC,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [7:0] RESP
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FIN} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_settle;
  logic [2:0] r_vec;
  logic [3:0] r_err;
  logic       r_pass;

  logic       w_settle_done;
  logic       w_exp;
  logic       w_mis;
  logic [3:0] w_err_nxt;
  logic       w_busy;

  assign w_settle_done = (r_settle == 4'(SETTLE_CYCLES - 1));
  // Only vector 000 yields a NOR output of 1.
  assign w_exp         = (r_vec == 3'd0);
  assign w_mis         = D ^ w_exp;
  assign w_err_nxt     = r_err + {3'b000, w_mis};
  assign w_busy        = (r_state == APPLY) || (r_state == SAMPLE);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (START) w_next = APPLY;
      APPLY:   if (w_settle_done) w_next = SAMPLE;
      SAMPLE:  w_next = (r_vec == 3'd7) ? FIN : APPLY;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_settle <= '0;
      r_vec    <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_settle <= '0;
            r_vec    <= '0;
            r_err    <= '0;
            r_pass   <= 1'b0;
          end
        end
        APPLY: r_settle <= w_settle_done ? 4'd0 : r_settle + 4'd1;
        SAMPLE: begin
          r_err <= w_err_nxt;
          // Wraps to 0 after vector 7, leaving the vector idle-clean for FIN.
          r_vec <= r_vec + 3'd1;
          // PASS is resolved on the SAMPLE->FIN edge so it is valid alongside DONE.
          if (r_vec == 3'd7) r_pass <= (w_err_nxt == 4'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef NOR_SEQ_CAPTURE_EN
  logic [7:0] r_resp;

  always_ff @(posedge CLK) begin
    if (RST)                              r_resp <= '0;
    else if (r_state == IDLE && START)    r_resp <= '0;
    else if (r_state == SAMPLE)           r_resp[r_vec] <= D;
  end

  assign RESP = r_resp;
`else
  assign RESP = 8'h00;
`endif

  assign VEC     = w_busy ? r_vec : 3'd0;
  assign A       = VEC[2];
  assign B       = VEC[1];
  assign C       = VEC[0];
  assign BUSY    = w_busy;
  assign DONE    = (r_state == FIN);
  assign PASS    = r_pass;
  assign ERR_CNT = r_err;

endmodule

// File: tb/tb_three_input_gate_sequencer.sv
// Scoreboard bench: expected run results queued at START, popped by a monitor on each DONE pulse.
module tb_three_input_gate_sequencer;
  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       RST, START, D;
  logic       A, B, C, BUSY, DONE, PASS;
  logic [2:0] VEC;
  logic [3:0] ERR_CNT;
  logic [7:0] RESP;

  logic       START1, D1;
  logic       A1, B1, C1, BUSY1, DONE1, PASS1;
  logic [2:0] VEC1;
  logic [3:0] ERR_CNT1;
  logic [7:0] RESP1;

  int         mode;
  logic [7:0] mask;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int busy_n   = 0;

  typedef struct {
    logic [3:0] err;
    logic       pass;
    logic [7:0] resp;
    int         busy;
  } exp_t;
  exp_t q[$];

  three_input_gate_sequencer #(.SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .START(START), .D(D),
    .A(A), .B(B), .C(C), .VEC(VEC), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS), .ERR_CNT(ERR_CNT), .RESP(RESP)
  );

  three_input_gate_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .D(D1),
    .A(A1), .B(B1), .C(C1), .VEC(VEC1), .BUSY(BUSY1), .DONE(DONE1),
    .PASS(PASS1), .ERR_CNT(ERR_CNT1), .RESP(RESP1)
  );

  always #5 CLK = ~CLK;

  // Gate model: 0 ideal NOR, 1 stuck-0, 2 stuck-1, 3 NOR with per-vector faults in mask.
  always_comb begin
    case (mode)
      0:       D = ~(A | B | C);
      1:       D = 1'b0;
      2:       D = 1'b1;
      default: D = ~(A | B | C) ^ mask[VEC];
    endcase
  end
  assign D1 = ~(A1 | B1 | C1);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int m, input logic [7:0] msk);
    exp_t e;
    logic nor_v, d_v;
    e.err  = 0;
    e.resp = 0;
    for (int i = 0; i < 8; i++) begin
      nor_v = (i == 0);
      case (m)
        0:       d_v = nor_v;
        1:       d_v = 1'b0;
        2:       d_v = 1'b1;
        default: d_v = nor_v ^ msk[i];
      endcase
      e.resp[i] = d_v;
      if (d_v != nor_v) e.err = e.err + 4'd1;
    end
    e.pass = (e.err == 0);
`ifndef NOR_SEQ_CAPTURE_EN
    e.resp = 8'h00;
`endif
    e.busy = 8 * (S + 1);
    q.push_back(e);
  endtask

  task automatic wait_q(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, q.size(), 0);
  endtask

  task automatic run(input int m, input logic [7:0] msk);
    mode = m;
    mask = msk;
    push(m, msk);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST) busy_n = 0;
    else begin
      if (BUSY) busy_n++;
      if (DONE) begin
        done_cnt++;
        chk("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("err_cnt", ERR_CNT, e.err);
          chk("pass", PASS, e.pass);
          chk("resp", RESP, e.resp);
          chk("busy_len", busy_n, e.busy);
        end
        busy_n = 0;
      end
    end
  end

  initial begin
    int cyc, gap, d0;
    logic [2:0] v;
    RST = 1'b1; START = 1'b0; START1 = 1'b0; mode = 0; mask = 8'h00;
    repeat (3) tick();
    chk("reset_state", {A, B, C, VEC, BUSY, DONE, PASS, ERR_CNT, RESP}, 0);
    RST = 1'b0;
    tick();

    // Ideal run with exact DONE timing; a stray START mid-run must be ignored.
    mode = 0;
    push(0, 8'h00);
    START = 1'b1;
    tick();
    START = 1'b0;
    cyc = 1;
    while (!DONE && cyc < 100) begin
      if (cyc == 5) START = 1'b1;
      if (cyc == 6) START = 1'b0;
      tick();
      cyc++;
    end
    chk("done_cycle", cyc, 25);
    START = 1'b0;
    tick();
    tick();
    chk("idle_hold", {BUSY, VEC, PASS, ERR_CNT}, {1'b0, 3'd0, 1'b1, 4'd0});
    wait_q("ideal");

    // Accepting START clears the previous PASS/ERR_CNT/RESP on that edge.
    run(2, 8'h00);
    chk("start_clears", {PASS, ERR_CNT, RESP}, 0);
    wait_q("stuck1");
    tick();
    chk("stuck1_hold", {PASS, ERR_CNT}, {1'b0, 4'd7});

    run(1, 8'h00);
    wait_q("stuck0");
    run(3, 8'hA4);
    wait_q("mask");

    // START held high: exactly one DONE, then a new run two cycles later.
    mode = 0;
    push(0, 8'h00);
    push(0, 8'h00);
    START = 1'b1;
    cyc = 0;
    while (!DONE && cyc < 100) begin tick(); cyc++; end
    gap = 0;
    tick();
    gap++;
    while (!BUSY && gap < 10) begin tick(); gap++; end
    START = 1'b0;
    chk("restart_gap", gap, 2);
    wait_q("held");

    // Abort at vector 4 with errors already counted.
    run(2, 8'h00);
    cyc = 0;
    while (VEC != 3'd4 && cyc < 100) begin tick(); cyc++; end
    chk("reach_vec4", VEC, 4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_state", {A, B, C, VEC, BUSY, DONE, ERR_CNT, RESP}, 0);
    d0 = done_cnt;
    repeat (40) tick();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_stays_idle", BUSY, 0);

    // SETTLE_CYCLES=1 instance: 16 busy cycles, vector advances every 2 cycles.
    START1 = 1'b1;
    tick();
    START1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      v = 3'(k / 2);
      chk("s1_step", {BUSY1, A1, B1, C1, VEC1}, {1'b1, v, v});
      tick();
    end
    chk("s1_done", {BUSY1, DONE1, PASS1, ERR_CNT1}, {1'b0, 1'b1, 1'b1, 4'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
